dmem_lsu: RTL and testbench

Load/store unit between the multicycle core's memory-stage control and the word-indexed data memory.
- Converts RV32I byte addresses and funct3 into word-index accesses.
- Sign/zero-extends LB/LH/LBU/LHU read data.
- Performs sub-word stores (SB/SH) as a read-modify-write, because the data memory only supports full-word writes.
- Core-side interface is a request/done handshake; memory-side ports connect 1:1 to the data memory.

---
 rtl/dmem_lsu_if.sv | 25 ++
 rtl/dmem_lsu.sv | 174 +++++++++++++++++
 tb/tb_dmem_lsu.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_lsu_if.sv
// Core-side request/done bus of the data-memory load/store unit.
// The core drives the master modport and dmem_lsu uses the slave modport.
interface dmem_lsu_if #(
  parameter int WIDTH = 32
) ();
  logic             req_i;
  logic             we_i;
  logic [2:0]       funct3_i;
  logic [31:0]      addr_i;
  logic [WIDTH-1:0] wdata_i;
  logic             busy_o;
  logic             done_o;
  logic [WIDTH-1:0] rdata_o;
  logic             misalign_o;

  modport master (
    output req_i, we_i, funct3_i, addr_i, wdata_i,
    input  busy_o, done_o, rdata_o, misalign_o
  );

  modport slave (
    input  req_i, we_i, funct3_i, addr_i, wdata_i,
    output busy_o, done_o, rdata_o, misalign_o
  );
endinterface

// File: rtl/dmem_lsu.sv
// RV32I load/store unit for a word-indexed data memory; SB/SH use read-modify-write.
// Optional feature macro MISALIGN_TRAP_EN: misaligned LH/LHU/SH/LW/SW complete at once with misalign_o.
module dmem_lsu #(
  parameter int WIDTH      = 32,
  parameter int DMEM_DEPTH = 2048
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  dmem_lsu_if.slave        lsu,
  output logic [31:0]      DMEM_Address_o,
  output logic [WIDTH-1:0] wd_data_o,
  output logic             write_en_DMEM_o,
  input  logic [WIDTH-1:0] DMEM_out_i
);

  if (WIDTH != 32 || DMEM_DEPTH < 1) begin : gUnsupported
    $error("dmem_lsu supports WIDTH = 32 and a positive DMEM_DEPTH only");
  end

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WRITE  = 2'd2,
    RESP   = 2'd3
  } state_e;

  state_e           state_q;
  logic [31:0]      addr_q;
  logic [2:0]       funct3_q;
  logic             we_q;
  logic [WIDTH-1:0] wdata_q;
  logic [WIDTH-1:0] rdata_q;
  logic             done_q;
  logic             writeEn_q;

  logic [7:0]       byteLane;
  logic [15:0]      halfLane;
  logic [WIDTH-1:0] loadExt;
  logic [WIDTH-1:0] mergedWord;
  logic             accessLegal;

  // Lane extraction, load extension and sub-word merge all work on the word read at addr_q.
  always_comb begin
    byteLane = DMEM_out_i[{addr_q[1:0], 3'b000} +: 8];
    halfLane = addr_q[1] ? DMEM_out_i[31:16] : DMEM_out_i[15:0];

    loadExt = '0;
    case (funct3_q)
      3'b000:  loadExt = {{(WIDTH-8){byteLane[7]}}, byteLane};
      3'b001:  loadExt = {{(WIDTH-16){halfLane[15]}}, halfLane};
      3'b010:  loadExt = DMEM_out_i;
      3'b100:  loadExt = {{(WIDTH-8){1'b0}}, byteLane};
      3'b101:  loadExt = {{(WIDTH-16){1'b0}}, halfLane};
      default: loadExt = '0;
    endcase

    mergedWord = DMEM_out_i;
    if (funct3_q[0]) begin
      mergedWord[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
    end else begin
      mergedWord[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
    end

    if (we_q) begin
      accessLegal = (funct3_q[2] == 1'b0) && (funct3_q[1:0] != 2'b11);
    end else begin
      accessLegal = (funct3_q != 3'b011) && (funct3_q[2:1] != 2'b11);
    end
  end

`ifdef MISALIGN_TRAP_EN
  logic misalignReq;
  logic misalign_q;

  always_comb begin
    misalignReq = 1'b0;
    if (lsu.funct3_i == 3'b010) begin
      misalignReq = (lsu.addr_i[1:0] != 2'b00);
    end else if (lsu.funct3_i == 3'b001 || (!lsu.we_i && lsu.funct3_i == 3'b101)) begin
      misalignReq = lsu.addr_i[0];
    end
  end

  assign lsu.misalign_o = misalign_q;
`else
  assign lsu.misalign_o = 1'b0;
`endif

  // SW writes straight from ACCESS; SB/SH register the merged word and write it in WRITE.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      funct3_q  <= '0;
      we_q      <= 1'b0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      done_q    <= 1'b0;
      writeEn_q <= 1'b0;
`ifdef MISALIGN_TRAP_EN
      misalign_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
`ifdef MISALIGN_TRAP_EN
          misalign_q <= 1'b0;
`endif
          if (lsu.req_i) begin
            addr_q   <= lsu.addr_i;
            funct3_q <= lsu.funct3_i;
            we_q     <= lsu.we_i;
            wdata_q  <= lsu.wdata_i;
`ifdef MISALIGN_TRAP_EN
            if (misalignReq) begin
              writeEn_q  <= 1'b0;
              done_q     <= 1'b1;
              misalign_q <= 1'b1;
              state_q    <= RESP;
            end else
`endif
            begin
              writeEn_q <= lsu.we_i && (lsu.funct3_i == 3'b010);
              state_q   <= ACCESS;
            end
          end
        end
        ACCESS: begin
          if (!accessLegal) begin
            rdata_q   <= '0;
            writeEn_q <= 1'b0;
            done_q    <= 1'b1;
            state_q   <= RESP;
          end else if (!we_q) begin
            rdata_q <= loadExt;
            done_q  <= 1'b1;
            state_q <= RESP;
          end else if (funct3_q == 3'b010) begin
            writeEn_q <= 1'b0;
            done_q    <= 1'b1;
            state_q   <= RESP;
          end else begin
            wdata_q   <= mergedWord;
            writeEn_q <= 1'b1;
            state_q   <= WRITE;
          end
        end
        WRITE: begin
          writeEn_q <= 1'b0;
          done_q    <= 1'b1;
          state_q   <= RESP;
        end
        RESP: begin
          done_q <= 1'b0;
`ifdef MISALIGN_TRAP_EN
          misalign_q <= 1'b0;
`endif
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign lsu.busy_o      = (state_q != IDLE);
  assign lsu.done_o      = done_q;
  assign lsu.rdata_o     = rdata_q;
  assign DMEM_Address_o  = {2'b00, addr_q[31:2]};
  assign wd_data_o       = wdata_q;
  // A store caught by reset must never reach the memory, even in the reset cycle itself.
  assign write_en_DMEM_o = writeEn_q & rstn_i;

endmodule

// File: tb/tb_dmem_lsu.sv
// Scoreboard bench for dmem_lsu: a byte-level reference model predicts each completion,
// and a negedge monitor checks every done_o pulse against the queued prediction.
module tb_dmem_lsu;

  typedef struct {
    logic [31:0] rdata;
    logic        misalign;
    int          lat;
    int          writes;
    int          memIdx;
    logic [31:0] memWord;
    int          issueCyc;
  } expT;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        loadMem = 1'b1;
  logic [31:0] memAddr;
  logic [31:0] memWData;
  logic [31:0] memRData;
  logic        memWe;
  logic [31:0] dmem   [0:63];
  logic [31:0] refMem [0:63];
  logic [31:0] lastRdata = 32'd0;
  expT         expQ[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          wrCount = 0;

  dmem_lsu_if #(.WIDTH(32)) bus ();

  dmem_lsu #(
    .WIDTH      (32),
    .DMEM_DEPTH (2048)
  ) dut (
    .clk_i           (clk),
    .rstn_i          (rstn),
    .lsu             (bus),
    .DMEM_Address_o  (memAddr),
    .wd_data_o       (memWData),
    .write_en_DMEM_o (memWe),
    .DMEM_out_i      (memRData)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Word-indexed memory: combinational read, write on the clock edge.
  assign memRData = dmem[memAddr[5:0]];

  always @(posedge clk) begin
    if (loadMem) begin
      for (int i = 0; i < 64; i++) dmem[i] <= refMem[i];
    end else if (memWe) begin
      dmem[memAddr[5:0]] <= memWData;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Reference model: byte-addressed semantics of RV32I loads/stores on a word array.
  task automatic modelAccess(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                             input logic [31:0] wd, output expT e);
    int          size;
    bit          sgn;
    bit          misal;
    int          idx;
    int          off;
    logic [31:0] mask;
    logic [31:0] v;
    size  = 0;
    sgn   = 1'b0;
    misal = 1'b0;
    idx   = int'((addr / 4) % 64);
    if (we) begin
      case (f3)
        3'd0: size = 1;
        3'd1: size = 2;
        3'd2: size = 4;
        default: size = 0;
      endcase
    end else begin
      case (f3)
        3'd0: begin size = 1; sgn = 1'b1; end
        3'd1: begin size = 2; sgn = 1'b1; end
        3'd2: size = 4;
        3'd4: size = 1;
        3'd5: size = 2;
        default: size = 0;
      endcase
    end
`ifdef MISALIGN_TRAP_EN
    misal = (size > 1) && ((addr % size) != 0);
`endif
    e.lat      = 2;
    e.writes   = 0;
    e.misalign = misal;
    e.memIdx   = idx;
    e.issueCyc = 0;
    if (misal) begin
      e.lat = 1;
    end else if (size == 0) begin
      lastRdata = 32'd0;
    end else begin
      off  = 8 * ((int'(addr % 4) / size) * size);
      mask = (size == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * size)) - 32'd1);
      if (!we) begin
        v = (refMem[idx] >> off) & mask;
        if (sgn && v[8 * size - 1]) v = v | ~mask;
        lastRdata = v;
      end else begin
        refMem[idx] = (refMem[idx] & ~(mask << off)) | ((wd & mask) << off);
        e.writes = 1;
        if (size < 4) e.lat = 3;
      end
    end
    e.rdata   = lastRdata;
    e.memWord = refMem[idx];
  endtask

  // Monitor: every completion must match the oldest outstanding prediction.
  always @(negedge clk) begin
    expT e;
    if (rstn) begin
      if (memWe) wrCount++;
      if (bus.done_o) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpected_done", 32'(bus.done_o), 32'd0);
        end else begin
          e = expQ.pop_front();
          checkOutput("rdata", bus.rdata_o, e.rdata);
          checkOutput("misalign", 32'(bus.misalign_o), 32'(e.misalign));
          checkOutput("latency", 32'(cyc - e.issueCyc), 32'(e.lat));
          checkOutput("write_count", 32'(wrCount), 32'(e.writes));
          checkOutput("mem_word", dmem[e.memIdx], e.memWord);
          wrCount = 0;
        end
      end
    end
  end

  task automatic waitIdle();
    int n;
    n = 0;
    @(negedge clk);
    while (bus.busy_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (bus.busy_o) checkOutput("idle_timeout", 32'(bus.busy_o), 32'd0);
  endtask

  task automatic applyStimulus(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                               input logic [31:0] wd);
    expT e;
    waitIdle();
    bus.req_i    = 1'b1;
    bus.we_i     = we;
    bus.funct3_i = f3;
    bus.addr_i   = addr;
    bus.wdata_i  = wd;
    modelAccess(we, f3, addr, wd, e);
    e.issueCyc = cyc;
    expQ.push_back(e);
    @(negedge clk);
    bus.req_i = 1'b0;
  endtask

  task automatic resetDut();
    rstn      = 1'b0;
    bus.req_i = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("wen_in_reset", 32'(memWe), 32'd0);
    rstn = 1'b1;
    expQ.delete();
    wrCount   = 0;
    lastRdata = 32'd0;
    checkOutput("reset_busy", 32'(bus.busy_o), 32'd0);
    checkOutput("reset_done", 32'(bus.done_o), 32'd0);
    checkOutput("reset_rdata", bus.rdata_o, 32'd0);
    checkOutput("reset_misalign", 32'(bus.misalign_o), 32'd0);
    checkOutput("reset_mem_addr", memAddr, 32'd0);
    checkOutput("reset_wd_data", memWData, 32'd0);
    checkOutput("reset_wen", 32'(memWe), 32'd0);
  endtask

  // A store request is raised while the unit is busy; it must be dropped entirely.
  task automatic pulseWhileBusy();
    applyStimulus(1'b0, 3'b010, 32'h20, 32'd0);
    bus.req_i    = 1'b1;
    bus.we_i     = 1'b1;
    bus.funct3_i = 3'b010;
    bus.addr_i   = 32'h20;
    bus.wdata_i  = 32'hA5A5_5A5A;
    @(negedge clk);
    bus.req_i = 1'b0;
  endtask

  // req_i held high across two LWs: the second is taken in the IDLE cycle after RESP.
  task automatic backToBack();
    expT e;
    expT e2;
    int  first;
    int  n;
    n = 0;
    waitIdle();
    bus.req_i    = 1'b1;
    bus.we_i     = 1'b0;
    bus.funct3_i = 3'b010;
    bus.addr_i   = 32'h10;
    bus.wdata_i  = 32'd0;
    modelAccess(1'b0, 3'b010, 32'h10, 32'd0, e);
    first      = cyc;
    e.issueCyc = first;
    expQ.push_back(e);
    while (cyc < first + 2 && n < 10) begin
      @(negedge clk);
      n++;
    end
    bus.addr_i = 32'h14;
    modelAccess(1'b0, 3'b010, 32'h14, 32'd0, e2);
    e2.issueCyc = first + 3;
    expQ.push_back(e2);
    repeat (2) @(negedge clk);
    bus.req_i = 1'b0;
  endtask

  // Reset asserted while an SB sits in its write cycle: no write, no done.
  task automatic abortStore();
    int issue;
    int n;
    n = 0;
    waitIdle();
    bus.req_i    = 1'b1;
    bus.we_i     = 1'b1;
    bus.funct3_i = 3'b000;
    bus.addr_i   = 32'h21;
    bus.wdata_i  = 32'h0000_0077;
    issue = cyc;
    @(negedge clk);
    bus.req_i = 1'b0;
    while (cyc < issue + 2 && n < 10) begin
      @(negedge clk);
      n++;
    end
    checkOutput("abort_wen_in_write", 32'(memWe), 32'd1);
    rstn = 1'b0;
    #1;
    checkOutput("abort_wen_gated", 32'(memWe), 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    wrCount   = 0;
    lastRdata = 32'd0;
    checkOutput("abort_busy", 32'(bus.busy_o), 32'd0);
    checkOutput("abort_done", 32'(bus.done_o), 32'd0);
    checkOutput("abort_no_write", dmem[8], refMem[8]);
    checkOutput("abort_rdata", bus.rdata_o, 32'd0);
    repeat (4) @(negedge clk);
  endtask

  initial begin
    int n;
    bus.req_i    = 1'b0;
    bus.we_i     = 1'b0;
    bus.funct3_i = 3'b000;
    bus.addr_i   = 32'd0;
    bus.wdata_i  = 32'd0;
    for (int i = 0; i < 64; i++) refMem[i] = $urandom;
    resetDut();
    loadMem = 1'b0;

    applyStimulus(1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF);
    applyStimulus(1'b0, 3'b000, 32'h13, 32'd0);
    applyStimulus(1'b0, 3'b100, 32'h13, 32'd0);
    applyStimulus(1'b0, 3'b001, 32'h12, 32'd0);
    applyStimulus(1'b0, 3'b101, 32'h10, 32'd0);
    applyStimulus(1'b1, 3'b000, 32'h11, 32'h0000_0055);
    applyStimulus(1'b1, 3'b001, 32'h12, 32'h0000_1234);
    waitIdle();
    checkOutput("word4_after_sb_sh", dmem[4], 32'h1234_55EF);
    applyStimulus(1'b0, 3'b010, 32'h11, 32'd0);
    waitIdle();
`ifdef MISALIGN_TRAP_EN
    checkOutput("lw_0x11_rdata", bus.rdata_o, 32'h0000_BEEF);
`else
    checkOutput("lw_0x11_rdata", bus.rdata_o, 32'h1234_55EF);
`endif

    pulseWhileBusy();
    backToBack();
    abortStore();

    for (int t = 0; t < 300; t++) begin
      applyStimulus(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                    32'($urandom_range(0, 255)), $urandom);
    end

    n = 0;
    while (expQ.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (expQ.size() != 0) checkOutput("drain_timeout", 32'(expQ.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
